// File: rtl/processor_pkg.sv
// processor_pkg: opcode, funct and ALU operation encodings shared by the processor files
package processor_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;
endpackage

// File: rtl/processor_control_unit.sv
// control_unit: main decoder, opcode in; datapath steering strobes and ALUop out
module control_unit
    import processor_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       regDst,
    output logic       branch,
    output logic       memRead,
    output logic       memToReg,
    output logic       memWrite,
    output logic       ALUSrc,
    output logic       regWrite,
    output logic       jump,
    output logic [1:0] ALUop
);
    always_comb begin
        regDst   = 1'b0;
        branch   = 1'b0;
        memRead  = 1'b0;
        memToReg = 1'b0;
        memWrite = 1'b0;
        ALUSrc   = 1'b0;
        regWrite = 1'b0;
        jump     = 1'b0;
        ALUop    = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
                ALUop    = ALU_FUNCT;
            end
            OP_LW: begin
                ALUSrc   = 1'b1;
                memToReg = 1'b1;
                regWrite = 1'b1;
                memRead  = 1'b1;
            end
            OP_SW: begin
                ALUSrc   = 1'b1;
                memWrite = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                ALUop  = ALU_SUB;
            end
            OP_ADDI: begin
                ALUSrc   = 1'b1;
                regWrite = 1'b1;
            end
            OP_J: jump = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/processor_dmem.sv
// processor_dmem: word-addressed data RAM, async read, sync write; not cleared by reset
module processor_dmem #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] memory [0:WORDS-1] = '{default: '0};
    assign rdata = memory[addr];
    always_ff @(posedge clk) begin
        if (we) memory[addr] <= wdata;
    end
endmodule

// File: rtl/processor_imem.sv
// processor_imem: read-only instruction store, async read; contents are loaded from outside
module processor_imem #(
    parameter int WORDS = 256
) (
    input  logic [7:0]  addr,
    output logic [31:0] rdata
);
    logic [31:0] memory [0:WORDS-1] = '{default: '0};
    assign rdata = memory[addr];
endmodule

// File: rtl/processor_regfile.sv
// processor_regfile: 32x32 register file, two async reads, one sync write; $0 hardwired to zero
module processor_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31] = '{default: '0};
    assign rd1 = (ra1 == 5'd0) ? '0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : registers[ra2];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we && wa != 5'd0) begin
            registers[wa] <= wd;
        end
    end
endmodule

// File: rtl/processor.sv
// processor: single-cycle MIPS-32 core (R-type add/sub/and/or/slt, lw, sw, beq, addi, j)
// Ports: clk - rising-edge clock; reset - synchronous active-high, clears PC and registers.
module processor
    import processor_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input logic clk,
    input logic reset
);
    logic [31:0] PC = '0;
    logic [31:0] waitingPCAddr, instruction, pc_plus4, imm_ext;
    logic [31:0] rs_val, rt_val, alu_b, alu_result, ram_rdata, write_data, fn_result;
    logic [4:0]  write_reg;
    logic        zero, slt;
    logic        regDst, branch, memRead, memToReg, memWrite, ALUSrc, regWrite, jump;
    logic [1:0]  ALUop;

    processor_imem #(.WORDS(IMEM_WORDS)) instMem0 (
        .addr(PC[9:2]), .rdata(instruction)
    );

    control_unit ControlUnit (
        .opcode(instruction[31:26]), .regDst(regDst), .branch(branch), .memRead(memRead),
        .memToReg(memToReg), .memWrite(memWrite), .ALUSrc(ALUSrc), .regWrite(regWrite),
        .jump(jump), .ALUop(ALUop)
    );

    processor_regfile regBank (
        .clk(clk), .reset(reset), .we(regWrite), .ra1(instruction[25:21]),
        .ra2(instruction[20:16]), .wa(write_reg), .wd(write_data), .rd1(rs_val), .rd2(rt_val)
    );

    // memRead only documents intent: the asynchronous read port is always live
    processor_dmem #(.WORDS(DMEM_WORDS)) RAM (
        .clk(clk), .we(memWrite && !reset), .addr(alu_result[9:2]),
        .wdata(rt_val), .rdata(ram_rdata)
    );

    always_comb begin
        imm_ext   = {{16{instruction[15]}}, instruction[15:0]};
        alu_b     = ALUSrc ? imm_ext : rt_val;
        slt       = $signed(rs_val) < $signed(alu_b);
        fn_result = instruction[5:0] == FN_ADD ? rs_val + alu_b :
                    instruction[5:0] == FN_SUB ? rs_val - alu_b :
                    instruction[5:0] == FN_AND ? rs_val & alu_b :
                    instruction[5:0] == FN_OR  ? rs_val | alu_b :
                    instruction[5:0] == FN_SLT ? {31'd0, slt} : '0;
        alu_result = ALUop == ALU_ADD   ? rs_val + alu_b :
                     ALUop == ALU_SUB   ? rs_val - alu_b :
                     ALUop == ALU_FUNCT ? fn_result : '0;
        zero       = alu_result == '0;
        write_reg  = regDst ? instruction[15:11] : instruction[20:16];
        write_data = memToReg ? ram_rdata : alu_result;
        pc_plus4   = PC + 32'd4;
        waitingPCAddr = jump ? {pc_plus4[31:28], instruction[25:0], 2'b00} :
                        (branch && zero) ? pc_plus4 + {imm_ext[29:0], 2'b00} : pc_plus4;
    end

    always_ff @(posedge clk) begin
        PC <= reset ? '0 : waitingPCAddr;
    end
endmodule

// File: tb/tb_processor.sv
// tb_processor: directed program vectors checking control, next PC, register results and reset
module tb_processor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;

    processor dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [9:0]  ctrl;
        logic [4:0]  rn;
        logic [31:0] rv;
        logic [31:0] npc;
    } vec_t;

    localparam logic [9:0] C_R    = 10'b1001000010;
    localparam logic [9:0] C_LW   = 10'b0111100000;
    localparam logic [9:0] C_SW   = 10'b0100010000;
    localparam logic [9:0] C_BEQ  = 10'b0000001001;
    localparam logic [9:0] C_ADDI = 10'b0101000000;
    localparam logic [9:0] C_J    = 10'b0000000100;
    localparam logic [9:0] C_NONE = 10'b0000000000;

    vec_t v [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] ctrl_now();
        return {dut.ControlUnit.regDst, dut.ControlUnit.ALUSrc, dut.ControlUnit.memToReg,
                dut.ControlUnit.regWrite, dut.ControlUnit.memRead, dut.ControlUnit.memWrite,
                dut.ControlUnit.branch, dut.ControlUnit.jump, dut.ControlUnit.ALUop};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic any_nonzero;
        v[0]  = '{32'h00, 32'h20010005, C_ADDI, 5'd1, 32'd5,          32'h04};
        v[1]  = '{32'h04, 32'h20020007, C_ADDI, 5'd2, 32'd7,          32'h08};
        v[2]  = '{32'h08, 32'h00221820, C_R,    5'd3, 32'd12,         32'h0C};
        v[3]  = '{32'h0C, 32'hAC030004, C_SW,   5'd3, 32'd12,         32'h10};
        v[4]  = '{32'h10, 32'h8C040004, C_LW,   5'd4, 32'd12,         32'h14};
        v[5]  = '{32'h14, 32'h0022282A, C_R,    5'd5, 32'd1,          32'h18};
        v[6]  = '{32'h18, 32'h00223022, C_R,    5'd6, 32'hFFFFFFFE,   32'h1C};
        v[7]  = '{32'h1C, 32'h20000009, C_ADDI, 5'd0, 32'd0,          32'h20};
        v[8]  = '{32'h20, 32'h10210001, C_BEQ,  5'd1, 32'd5,          32'h28};
        v[9]  = '{32'h28, 32'h00000000, C_R,    5'd0, 32'd0,          32'h2C};
        v[10] = '{32'h2C, 32'h00222024, C_R,    5'd4, 32'd5,          32'h30};
        v[11] = '{32'h30, 32'h00222825, C_R,    5'd5, 32'd7,          32'h34};
        v[12] = '{32'h34, 32'h10220003, C_BEQ,  5'd2, 32'd7,          32'h38};
        v[13] = '{32'h38, 32'h00220827, C_R,    5'd1, 32'd0,          32'h3C};
        v[14] = '{32'h3C, 32'h3C01FFFF, C_NONE, 5'd1, 32'd0,          32'h40};
        v[15] = '{32'h40, 32'h2008FFFF, C_ADDI, 5'd8, 32'hFFFFFFFF,   32'h44};
        v[16] = '{32'h44, 32'h08000000, C_J,    5'd8, 32'hFFFFFFFF,   32'h00};
        for (int i = 0; i < 17; i++) dut.instMem0.memory[v[i].addr[9:2]] = v[i].instr;
        // sits in the shadow of the taken beq; executing it would corrupt $1
        dut.instMem0.memory[9] = 32'h20010063;

        #1;
        chk("powerup_pc", dut.PC, 32'h0);
        step();
        reset = 1'b0;
        chk("reset_pc", dut.PC, 32'h0);
        chk("reset_r1", dut.regBank.registers[1], 32'h0);

        for (int i = 0; i < 17; i++) begin
            chk($sformatf("v%0d_instr", i), dut.instruction, v[i].instr);
            chk($sformatf("v%0d_ctrl", i), {22'd0, ctrl_now()}, {22'd0, v[i].ctrl});
            chk($sformatf("v%0d_nextpc", i), dut.waitingPCAddr, v[i].npc);
            step();
            chk($sformatf("v%0d_reg%0d", i, v[i].rn), dut.regBank.registers[v[i].rn], v[i].rv);
            chk($sformatf("v%0d_pc", i), dut.PC, v[i].npc);
        end

        chk("ram_word1", dut.RAM.memory[1], 32'd12);

        // rerun from 0 for one instruction, then reset mid-program
        step();
        chk("rerun_r1", dut.regBank.registers[1], 32'd5);
        chk("rerun_pc", dut.PC, 32'h04);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_pc", dut.PC, 32'h0);
        any_nonzero = 1'b0;
        for (int r = 0; r < 32; r++) if (dut.regBank.registers[r] !== 32'h0) any_nonzero = 1'b1;
        chk("midreset_regs_zero", {31'd0, any_nonzero}, 32'd0);
        chk("midreset_ram_kept", dut.RAM.memory[1], 32'd12);
        step();
        chk("after_reset_r1", dut.regBank.registers[1], 32'd5);
        chk("after_reset_pc", dut.PC, 32'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 Parameter IMEM_WORDS, default 256, instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 256, data memory depth in 32-bit words.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 No other ports; observation and program load SHALL use the fixed hierarchical names in REQ-006.
REQ-006 Hierarchical names SHALL exist:
- PC[31:0]; waitingPCAddr[31:0] (combinational next PC); instruction[31:0].
- ControlUnit.{regDst, branch, memRead, memToReg, memWrite, ALUSrc, regWrite, jump}, 1 bit each; ControlUnit.ALUop[1:0].
- regBank.registers[0:31][31:0]; RAM.memory[0:DMEM_WORDS-1][31:0]; instMem0.memory[0:IMEM_WORDS-1][31:0].

Function
REQ-007 Single-cycle MIPS-32: one instruction per rising clk edge, no pipeline, no stalls.
REQ-008 instruction = instMem0.memory[PC[9:2]]; combinational read, no write port; contents loaded externally.
REQ-009 Control per opcode, listed as regDst,ALUSrc,memToReg,regWrite,memRead,memWrite,branch,jump,ALUop:
- R-type 000000 = 1,0,0,1,0,0,0,0,10
- lw 100011 = 0,1,1,1,1,0,0,0,00
- sw 101011 = 0,1,0,0,0,1,0,0,00
- beq 000100 = 0,0,0,0,0,0,1,0,01
- addi 001000 = 0,1,0,1,0,0,0,0,00
- j 000010 = jump=1, all others 0, ALUop 00
- any other opcode: all 0 (no-op).
REQ-010 ALU operation: ALUop 00 = add; 01 = subtract; 10 = decoded from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 signed slt (result 1 or 0); any other funct yields result 0.
REQ-011 Arithmetic is 32-bit two's complement, wrap-around, overflow ignored; zero flag = (ALU result == 0).
REQ-012 ALU operand B = ALUSrc ? sign-extended imm[15:0] : rt value.
REQ-013 Write register = regDst ? rd : rt; write data = memToReg ? RAM read data : ALU result.
REQ-014 Register file: two asynchronous reads (rs, rt), one synchronous write when regWrite=1; register 0 always reads 0 and writes to it are discarded.
REQ-015 Data memory word index = ALU result[9:2] (upper bits ignored, wraps); asynchronous read; write of rt value on rising edge when memWrite=1.
REQ-016 waitingPCAddr: jump -> {PC+4[31:28], instr[25:0], 00}; else branch & zero -> PC+4 + (sext(imm)<<2); else PC+4. PC <= waitingPCAddr each edge.
REQ-017 All-zero word executes as R-type with funct 0: result 0 written to register 0, discarded, so it behaves as a NOP.

Reset
REQ-018 On a rising edge with reset=1: PC <= 0 and all 32 registers <= 0; no register or RAM write occurs that cycle.
REQ-019 Reset does not clear RAM or instruction memory.
REQ-020 Power-up (initial) value is 0 for PC, all registers and all RAM words, so execution starts at address 0 even if reset sees no clock edge.
REQ-021 Reset asserted mid-program takes effect at the next edge; the in-flight instruction is abandoned.

Structure
REQ-022 Shared package processor_pkg holds opcode constants, funct constants and ALUop encodings.
REQ-023 The one natural sub-module is control_unit, instanced as ControlUnit.
REQ-024 Register file, data memory and instruction memory are instances regBank, RAM and instMem0, with arrays named registers and memory.

Verification
REQ-025 Program 0x20010005, 0x20020007, 0x00221820 -> after 3 edges: registers[1]=5, registers[2]=7, registers[3]=12, PC=0x0C.
REQ-026 Continue with 0xAC030004, 0x8C040004 -> RAM.memory[1]=12, registers[4]=12; during lw memRead=1 and memToReg=1.
REQ-027 With $1=5, $2=7: 0x0022282A -> registers[5]=1; 0x00223022 -> registers[6]=0xFFFFFFFE.
REQ-028 beq 0x10210001 at PC=0x20 -> waitingPCAddr=0x28, branch=1; j 0x08000000 -> next PC=0, jump=1.
REQ-029 Write to $0 (0x20000009) -> registers[0] stays 0; all-zero instruction -> only PC advances by 4.
REQ-030 Assert reset for one edge mid-run -> PC=0 and all registers 0; RAM contents retained.
